rx_frame_buffer: RTL and testbench
==================================

RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter DEPTH, default 16: byte capacity of the frame store; power of 2, range 4..256.
REQ-002 Parameter DROP_ON_ERROR, default 1: 1 discards frames with parity or sequence errors; 0 keeps them and reports the error.
REQ-003 clk  input  1  13.56MHz recovered carrier clock, single clock domain.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 in_soc / in_eoc  input  1 each  start / end of communication pulses from rx.
REQ-006 in_data  input  8  received byte, LSB first on air.
REQ-007 in_data_bits  input  3  valid bits in in_data; 0 means 8, 1..7 means a partial byte.
REQ-008 in_data_valid  input  1  in_data and in_data_bits are valid this cycle.
REQ-009 in_sequence_error / in_parity_error  input  1 each  error pulses from rx.
REQ-010 rd_data  output  8  frame byte at the read pointer.
REQ-011 rd_valid / rd_ready / rd_last  out/in/out  1 each  read handshake; rd_last marks the final byte.
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes or is dropped.
REQ-013 frame_len  output  clog2(DEPTH+1)  stored byte count, partial last byte included.
REQ-014 frame_bits  output  3  valid bits in the last byte (0 = 8).
REQ-015 frame_err / frame_overflow / frame_dropped / busy_drop  output  1 each  status; busy_drop is a pulse.

Function
REQ-016 States: IDLE, RECV, DROP, HOLD.
REQ-017 IDLE: in_soc moves to RECV and clears len and all flags; other inputs are ignored.
REQ-018 RECV, on in_data_valid: store the byte at index len and increment len.
REQ-019 RECV, in_soc: restarts the frame with len=0 and flags cleared.
REQ-020 A byte with in_data_bits!=0 followed by a further in_data_valid sets frame_err as a sequence error.
REQ-021 A parity or sequence error in RECV sets frame_err.
REQ-022 On that error, DROP_ON_ERROR=1 moves to DROP; DROP_ON_ERROR=0 stays in RECV.
REQ-023 A byte arriving at len==DEPTH is discarded; frame_overflow is set and the state moves to DROP.
REQ-024 in_eoc in RECV with len>0 moves to HOLD and pulses frame_done one cycle later; frame_len/frame_bits are then stable until IDLE.
REQ-025 in_eoc and in_data_valid in the same cycle: store the byte first, then close the frame.
REQ-026 in_eoc in RECV with len==0 pulses frame_done with frame_len=0 and returns to IDLE; rd_valid never asserts.
REQ-027 DROP: ignore data; on in_eoc pulse frame_done with frame_dropped=1 and return to IDLE.
REQ-028 HOLD: rd_valid=1 while rd_ptr<len; rd_data=mem[rd_ptr] combinationally; rd_last=(rd_ptr==len-1).
REQ-029 HOLD: rd_valid&&rd_ready increments rd_ptr; the transfer with rd_last returns to IDLE next cycle.
REQ-030 HOLD: in_soc pulses busy_drop; the incoming frame is ignored and the stored frame is untouched.
REQ-031 rd_valid is 0 in every state except HOLD; rd_ready is ignored outside HOLD.

Reset
REQ-032 rst forces IDLE; len, rd_ptr and all outputs are 0 on the next edge.
REQ-033 rst mid-frame or mid-read discards the frame with no frame_done pulse.
REQ-034 Memory contents are not reset.

Configuration
REQ-035 Macro RX_FRAME_BUFFER_CRC_CHECK_EN adds output frame_crc_ok (1 bit).
REQ-036 CRC_A: reflected polynomial 0x8408, initial value 0x6363, updated over every full stored byte of the frame.
REQ-037 frame_crc_ok=1 in HOLD iff residue==0x0000, len>=3 and frame_bits==0; it is 0 elsewhere and at reset.
REQ-038 Without the macro, neither the port nor the CRC logic exists; all other behaviour is identical.

Verification
REQ-039 soc; bytes 0x93,0x20; eoc; rd_ready=1 -> frame_done, len=2, reads 0x93 then 0x20 (rd_last on 2nd), IDLE.
REQ-040 soc; 0x26 with bits=7; eoc -> len=1, frame_bits=7, single read 0x26 with rd_last.
REQ-041 DROP_ON_ERROR=1: soc, 0x50, parity_error, 0x00, eoc -> frame_done, frame_dropped=1, frame_err=1, no rd_valid.
REQ-042 DEPTH=4: soc, 5 bytes, eoc -> frame_overflow=1, frame_dropped=1; then soc during HOLD of a valid frame -> busy_drop pulse, stored data unchanged.
REQ-043 CRC_EN: frame 0x00,0x00,0xA0,0x1E -> frame_crc_ok=1; last byte changed to 0x1F -> 0.
REQ-044 rst asserted after 2 bytes of RECV, then released -> all outputs 0; a new 1-byte frame is received correctly.

Source files
------------

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: stores one received frame from the rx front end and replays it
// over a valid/ready read port.
//
// Ports
//   clk_i, rst_i                 single clock domain, synchronous active-high reset
//   in_soc_i / in_eoc_i          start / end of communication pulses
//   in_data_i, in_data_bits_i    received byte and its valid bit count (0 = 8)
//   in_data_valid_i              qualifies in_data_i / in_data_bits_i
//   in_sequence_error_i,
//   in_parity_error_i            error pulses from rx
//   rd_data_o, rd_valid_o,
//   rd_ready_i, rd_last_o        read handshake for the held frame
//   frame_done_o                 one-cycle pulse when a frame completes or is dropped
//   frame_len_o, frame_bits_o    stored byte count and valid bits of the last byte
//   frame_err_o, frame_overflow_o,
//   frame_dropped_o              frame status flags, cleared on the next start
//   busy_drop_o                  pulse: a new frame arrived while one was still held
//   frame_crc_ok_o               only with RX_FRAME_BUFFER_CRC_CHECK_EN defined:
//                                CRC_A residue check of the held frame
module rx_frame_buffer #(
  parameter int unsigned DEPTH         = 16,
  parameter bit          DROP_ON_ERROR = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_soc_i,
  input  logic                         in_eoc_i,
  input  logic [7:0]                   in_data_i,
  input  logic [2:0]                   in_data_bits_i,
  input  logic                         in_data_valid_i,
  input  logic                         in_sequence_error_i,
  input  logic                         in_parity_error_i,
  output logic [7:0]                   rd_data_o,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic                         rd_last_o,
  output logic                         frame_done_o,
  output logic [$clog2(DEPTH+1)-1:0]   frame_len_o,
  output logic [2:0]                   frame_bits_o,
  output logic                         frame_err_o,
  output logic                         frame_overflow_o,
  output logic                         frame_dropped_o,
  output logic                         busy_drop_o
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
  ,
  output logic                         frame_crc_ok_o
`endif
);

  localparam int unsigned LenW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop, StHold} state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]      bits_q, bits_d;
  logic            partial_q, partial_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            dropped_q, dropped_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            mem_we;
  logic            frame_start;
  logic [7:0]      mem_q [DEPTH];

  logic rd_valid, rd_last, rd_fire, err_hit, ovf_hit;

  // A further byte after a partial byte is a sequence error too.
  assign err_hit  = in_sequence_error_i | in_parity_error_i | (in_data_valid_i & partial_q);
  assign ovf_hit  = in_data_valid_i & (len_q == LenW'(DEPTH));
  assign rd_valid = (state_q == StHold) && (rd_ptr_q < len_q);
  assign rd_last  = rd_valid && (rd_ptr_q == len_q - LenW'(1));
  assign rd_fire  = rd_valid & rd_ready_i;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    bits_d      = bits_q;
    partial_d   = partial_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    dropped_d   = dropped_q;
    done_d      = 1'b0;
    busy_d      = 1'b0;
    mem_we      = 1'b0;
    frame_start = in_soc_i && ((state_q == StIdle) || (state_q == StRecv));

    if (frame_start) begin
      state_d   = StRecv;
      len_d     = '0;
      rd_ptr_d  = '0;
      bits_d    = '0;
      partial_d = 1'b0;
      err_d     = 1'b0;
      ovf_d     = 1'b0;
      dropped_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRecv: begin
          if (err_hit) err_d = 1'b1;
          if (ovf_hit) ovf_d = 1'b1;
          if ((err_hit && DROP_ON_ERROR) || ovf_hit) begin
            // An eoc in the same cycle closes the frame as dropped right away.
            if (in_eoc_i) begin
              done_d    = 1'b1;
              dropped_d = 1'b1;
              state_d   = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            if (in_data_valid_i) begin
              mem_we    = 1'b1;
              len_d     = len_q + LenW'(1);
              bits_d    = in_data_bits_i;
              partial_d = (in_data_bits_i != 3'd0);
            end
            // len_d already counts a byte stored in this same cycle.
            if (in_eoc_i) begin
              done_d  = 1'b1;
              state_d = (len_d != '0) ? StHold : StIdle;
            end
          end
        end
        StDrop: begin
          if (in_eoc_i) begin
            done_d    = 1'b1;
            dropped_d = 1'b1;
            state_d   = StIdle;
          end
        end
        StHold: begin
          if (in_soc_i) busy_d = 1'b1;
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + LenW'(1);
            if (rd_last) state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      rd_ptr_q  <= '0;
      bits_q    <= '0;
      partial_q <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dropped_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rd_ptr_q  <= rd_ptr_d;
      bits_q    <= bits_d;
      partial_q <= partial_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      dropped_q <= dropped_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Frame store is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[len_q[PtrW-1:0]] <= in_data_i;
  end

  assign rd_data_o        = rd_valid ? mem_q[rd_ptr_q[PtrW-1:0]] : 8'h00;
  assign rd_valid_o       = rd_valid;
  assign rd_last_o        = rd_last;
  assign frame_done_o     = done_q;
  assign frame_len_o      = len_q;
  assign frame_bits_o     = bits_q;
  assign frame_err_o      = err_q;
  assign frame_overflow_o = ovf_q;
  assign frame_dropped_o  = dropped_q;
  assign busy_drop_o      = busy_q;

`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
  // CRC_A, reflected 0x8408, bit-serial over one byte LSB first.
  function automatic logic [15:0] crc_a_update(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  logic [15:0] crc_q, crc_d;

  // Partial bytes are stored but never folded into the CRC.
  always_comb begin
    crc_d = crc_q;
    if (frame_start) begin
      crc_d = 16'h6363;
    end else if (mem_we && (in_data_bits_i == 3'd0)) begin
      crc_d = crc_a_update(crc_q, in_data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) crc_q <= 16'h6363;
    else       crc_q <= crc_d;
  end

  assign frame_crc_ok_o = (state_q == StHold) && (crc_q == 16'h0000) &&
                          (len_q >= LenW'(3)) && (bits_q == 3'd0);
`endif

endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, soc, eoc, dv, seq, par, rd_ready;
  logic [7:0] data;
  logic [2:0] bits;

  // Main instance: DEPTH 16, drop on error.
  logic [7:0] m_rd_data;
  logic       m_rd_valid, m_rd_last, m_done, m_err, m_ovf, m_drop, m_busy;
  logic [4:0] m_len;
  logic [2:0] m_bits;
  // Small instance: DEPTH 4, keep errored frames.
  logic [7:0] s_rd_data;
  logic       s_rd_valid, s_rd_last, s_done, s_err, s_ovf, s_drop, s_busy;
  logic [2:0] s_len;
  logic [2:0] s_bits;
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
  logic       m_crc, s_crc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rx_frame_buffer #(.DEPTH(16), .DROP_ON_ERROR(1'b1)) u_main (
    .clk_i(clk), .rst_i(rst), .in_soc_i(soc), .in_eoc_i(eoc), .in_data_i(data),
    .in_data_bits_i(bits), .in_data_valid_i(dv), .in_sequence_error_i(seq),
    .in_parity_error_i(par), .rd_data_o(m_rd_data), .rd_valid_o(m_rd_valid),
    .rd_ready_i(rd_ready), .rd_last_o(m_rd_last), .frame_done_o(m_done),
    .frame_len_o(m_len), .frame_bits_o(m_bits), .frame_err_o(m_err),
    .frame_overflow_o(m_ovf), .frame_dropped_o(m_drop), .busy_drop_o(m_busy)
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
    , .frame_crc_ok_o(m_crc)
`endif
  );

  rx_frame_buffer #(.DEPTH(4), .DROP_ON_ERROR(1'b0)) u_small (
    .clk_i(clk), .rst_i(rst), .in_soc_i(soc), .in_eoc_i(eoc), .in_data_i(data),
    .in_data_bits_i(bits), .in_data_valid_i(dv), .in_sequence_error_i(seq),
    .in_parity_error_i(par), .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid),
    .rd_ready_i(rd_ready), .rd_last_o(s_rd_last), .frame_done_o(s_done),
    .frame_len_o(s_len), .frame_bits_o(s_bits), .frame_err_o(s_err),
    .frame_overflow_o(s_ovf), .frame_dropped_o(s_drop), .busy_drop_o(s_busy)
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
    , .frame_crc_ok_o(s_crc)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] b);
    data = d; bits = b; dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic pulse_soc();
    soc = 1'b1; tick(); soc = 1'b0;
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1; tick(); eoc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
  // Table-free byte-wise CRC_A formulation, independent of the bit-serial form.
  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [7:0] b);
    logic [7:0] ch;
    ch = b ^ crc[7:0];
    ch = ch ^ (ch << 4);
    return (crc >> 8) ^ {ch, 8'h00} ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
  endfunction
`endif

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({m_rd_data, m_rd_valid, m_rd_last, m_done, m_len, m_bits, m_err, m_ovf, m_drop,
         m_busy} !== '0) begin
      n_bad++; $display("FAIL reset_main: outputs %h, required all 0",
        {m_rd_data, m_rd_valid, m_rd_last, m_done, m_len, m_bits, m_err, m_ovf, m_drop, m_busy});
    end
    n_cmp++;
    if ({s_rd_data, s_rd_valid, s_rd_last, s_done, s_len, s_bits, s_err, s_ovf, s_drop,
         s_busy} !== '0) begin
      n_bad++; $display("FAIL reset_small: outputs %h, required all 0",
        {s_rd_data, s_rd_valid, s_rd_last, s_done, s_len, s_bits, s_err, s_ovf, s_drop, s_busy});
    end
  endtask

  task automatic test_basic();
    pulse_soc();
    send_byte(8'h93, 3'd0);
    send_byte(8'h20, 3'd0);
    pulse_eoc();
    n_cmp++;
    if ({m_done, m_len, m_bits, m_drop} !== {1'b1, 5'd2, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL basic_done: done/len/bits/drop=%b/%0d/%0d/%b, required 1/2/0/0",
        m_done, m_len, m_bits, m_drop);
    end
    rd_ready = 1'b1;
    n_cmp++;
    if ({m_rd_valid, m_rd_data, m_rd_last} !== {1'b1, 8'h93, 1'b0}) begin
      n_bad++; $display("FAIL basic_rd0: valid/data/last=%b/%h/%b, required 1/93/0",
        m_rd_valid, m_rd_data, m_rd_last);
    end
    tick();
    n_cmp++;
    if ({m_done, m_rd_valid, m_rd_data, m_rd_last} !== {1'b0, 1'b1, 8'h20, 1'b1}) begin
      n_bad++; $display("FAIL basic_rd1: done/valid/data/last=%b/%b/%h/%b, required 0/1/20/1",
        m_done, m_rd_valid, m_rd_data, m_rd_last);
    end
    tick();
    rd_ready = 1'b0;
    tick();
    n_cmp++;
    if (m_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle: rd_valid=%b, required 0", m_rd_valid);
    end
  endtask

  task automatic test_partial();
    pulse_soc();
    send_byte(8'h26, 3'd7);
    pulse_eoc();
    n_cmp++;
    if ({m_done, m_len, m_bits, m_rd_valid, m_rd_data, m_rd_last} !==
        {1'b1, 5'd1, 3'd7, 1'b1, 8'h26, 1'b1}) begin
      n_bad++; $display("FAIL partial: done/len/bits/valid/data/last=%b/%0d/%0d/%b/%h/%b, %s",
        m_done, m_len, m_bits, m_rd_valid, m_rd_data, m_rd_last, "required 1/1/7/1/26/1");
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_cmp++;
    if (m_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL partial_idle: rd_valid=%b, required 0", m_rd_valid);
    end
  endtask

  task automatic test_error();
    pulse_soc();
    send_byte(8'h50, 3'd0);
    par = 1'b1; tick(); par = 1'b0;
    send_byte(8'h00, 3'd0);
    n_cmp++;
    if (m_rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL err_novalid: rd_valid=%b, required 0", m_rd_valid);
    end
    pulse_eoc();
    n_cmp++;
    if ({m_done, m_drop, m_err, m_rd_valid} !== 4'b1110) begin
      n_bad++; $display("FAIL err_drop: done/dropped/err/valid=%b%b%b%b, required 1110",
        m_done, m_drop, m_err, m_rd_valid);
    end
    // Keep-on-error instance holds both bytes and reports the error.
    n_cmp++;
    if ({s_done, s_err, s_drop, s_len} !== {1'b1, 1'b1, 1'b0, 3'd2}) begin
      n_bad++; $display("FAIL err_keep: done/err/dropped/len=%b/%b/%b/%0d, required 1/1/0/2",
        s_done, s_err, s_drop, s_len);
    end
    rd_ready = 1'b1;
    n_cmp++;
    if ({s_rd_valid, s_rd_data, s_rd_last} !== {1'b1, 8'h50, 1'b0}) begin
      n_bad++; $display("FAIL err_keep_rd0: valid/data/last=%b/%h/%b, required 1/50/0",
        s_rd_valid, s_rd_data, s_rd_last);
    end
    tick();
    n_cmp++;
    if ({s_rd_valid, s_rd_data, s_rd_last} !== {1'b1, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL err_keep_rd1: valid/data/last=%b/%h/%b, required 1/00/1",
        s_rd_valid, s_rd_data, s_rd_last);
    end
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_empty();
    pulse_soc();
    pulse_eoc();
    n_cmp++;
    if ({m_done, m_len, m_rd_valid, m_drop} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL empty: done/len/valid/dropped=%b/%0d/%b/%b, required 1/0/0/0",
        m_done, m_len, m_rd_valid, m_drop);
    end
    tick();
    n_cmp++;
    if ({m_done, m_rd_valid} !== 2'b00) begin
      n_bad++; $display("FAIL empty_after: done/valid=%b%b, required 00", m_done, m_rd_valid);
    end
  endtask

  task automatic test_overflow_busy();
    pulse_soc();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 3'd0);
    pulse_eoc();
    n_cmp++;
    if ({s_done, s_ovf, s_drop, s_rd_valid} !== 4'b1110) begin
      n_bad++; $display("FAIL ovf: done/overflow/dropped/valid=%b%b%b%b, required 1110",
        s_done, s_ovf, s_drop, s_rd_valid);
    end
    do_reset();
    pulse_soc();
    send_byte(8'hC1, 3'd0);
    send_byte(8'hC2, 3'd0);
    pulse_eoc();
    pulse_soc();
    n_cmp++;
    if (s_busy !== 1'b1) begin
      n_bad++; $display("FAIL busy_pulse: busy_drop=%b, required 1", s_busy);
    end
    send_byte(8'hEE, 3'd0);
    send_byte(8'hEF, 3'd0);
    pulse_eoc();
    n_cmp++;
    if ({s_busy, s_len, s_done} !== {1'b0, 3'd2, 1'b0}) begin
      n_bad++; $display("FAIL busy_after: busy/len/done=%b/%0d/%b, required 0/2/0",
        s_busy, s_len, s_done);
    end
    rd_ready = 1'b1;
    n_cmp++;
    if ({s_rd_valid, s_rd_data} !== {1'b1, 8'hC1}) begin
      n_bad++; $display("FAIL busy_rd0: valid/data=%b/%h, required 1/c1", s_rd_valid, s_rd_data);
    end
    tick();
    n_cmp++;
    if ({s_rd_valid, s_rd_data, s_rd_last} !== {1'b1, 8'hC2, 1'b1}) begin
      n_bad++; $display("FAIL busy_rd1: valid/data/last=%b/%h/%b, required 1/c2/1",
        s_rd_valid, s_rd_data, s_rd_last);
    end
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_soc();
    send_byte(8'h31, 3'd0);
    send_byte(8'h32, 3'd0);
    do_reset();
    n_cmp++;
    if ({m_rd_data, m_rd_valid, m_rd_last, m_done, m_len, m_bits, m_err, m_ovf, m_drop,
         m_busy} !== '0) begin
      n_bad++; $display("FAIL reset_mid: outputs %h, required all 0",
        {m_rd_data, m_rd_valid, m_rd_last, m_done, m_len, m_bits, m_err, m_ovf, m_drop, m_busy});
    end
    tick();
    n_cmp++;
    if (m_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_done: frame_done=%b, required 0", m_done);
    end
    pulse_soc();
    send_byte(8'hA5, 3'd0);
    pulse_eoc();
    n_cmp++;
    if ({m_done, m_len, m_rd_valid, m_rd_data, m_rd_last} !==
        {1'b1, 5'd1, 1'b1, 8'hA5, 1'b1}) begin
      n_bad++; $display("FAIL reset_new: done/len/valid/data/last=%b/%0d/%b/%h/%b, %s",
        m_done, m_len, m_rd_valid, m_rd_data, m_rd_last, "required 1/1/1/a5/1");
    end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
  task automatic test_crc();
    logic [7:0] last_b [2];
    logic       want [2];
    last_b[0] = 8'h1E; want[0] = 1'b1;
    last_b[1] = 8'h1F; want[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pulse_soc();
      send_byte(8'h00, 3'd0);
      send_byte(8'h00, 3'd0);
      send_byte(8'hA0, 3'd0);
      send_byte(last_b[k], 3'd0);
      pulse_eoc();
      n_cmp++;
      if ({m_crc, s_crc} !== {want[k], want[k]}) begin
        n_bad++; $display("FAIL crc_%0d: crc_ok main/small=%b%b, required %b%b",
          k, m_crc, s_crc, want[k], want[k]);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rd_ready = 1'b0;
      n_cmp++;
      if (m_crc !== 1'b0) begin
        n_bad++; $display("FAIL crc_idle_%0d: crc_ok=%b, required 0", k, m_crc);
      end
    end
  endtask
`endif

  // Random frames on the main instance checked against a queue-based frame model.
  task automatic test_random();
    logic [7:0] fd[$];
    logic [2:0] fb[$];
    logic [7:0] e_q[$];
    logic [2:0] e_bits;
    bit         e_err, e_ovf, e_drop, partial;
    int         n, err_at, idx, cyc, w;
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
    logic [15:0] crc;
    bit          e_crc;
`endif
    do_reset();
    for (int it = 0; it < 40; it++) begin
      fd.delete(); fb.delete(); e_q.delete();
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) begin
        fd.push_back(8'($urandom));
        if (i == n - 1 && $urandom_range(0, 3) == 0)      fb.push_back(3'($urandom_range(1, 7)));
        else if (i != n - 1 && $urandom_range(0, 15) == 0) fb.push_back(3'($urandom_range(1, 7)));
        else                                               fb.push_back(3'd0);
      end
      err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n) : -1;

      // Model: an error or overflow drops the frame; later events are ignored.
      e_err = 0; e_ovf = 0; e_drop = 0; partial = 0; e_bits = 3'd0;
      for (int i = 0; i <= n; i++) begin
        if (err_at == i && !e_drop) begin e_err = 1; e_drop = 1; end
        if (i == n || e_drop) continue;
        if (partial) e_err = 1;
        if (e_q.size() == 16) e_ovf = 1;
        if (partial || e_q.size() == 16) begin e_drop = 1; continue; end
        e_q.push_back(fd[i]);
        partial = (fb[i] != 3'd0);
        e_bits = fb[i];
      end
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
      crc = 16'h6363;
      for (int i = 0; i < e_q.size(); i++) begin
        if (!(i == e_q.size() - 1 && e_bits != 3'd0)) crc = crc_ref(crc, e_q[i]);
      end
      e_crc = !e_drop && e_q.size() >= 3 && e_bits == 3'd0 && crc == 16'h0000;
`endif

      pulse_soc();
      for (int i = 0; i <= n; i++) begin
        if (err_at == i) begin
          if ($urandom_range(0, 1) == 1) par = 1'b1; else seq = 1'b1;
          tick();
          par = 1'b0; seq = 1'b0;
        end
        if (i < n) send_byte(fd[i], fb[i]);
      end
      pulse_eoc();

      w = 0;
      while (m_done !== 1'b1 && w < 3) begin tick(); w++; end
      n_cmp++;
      if (m_done !== 1'b1) begin
        n_bad++; $display("FAIL rnd%0d_done: frame_done never seen within bound", it);
      end
      n_cmp++;
      if ({m_drop, m_err, m_ovf} !== {e_drop, e_err, e_ovf}) begin
        n_bad++; $display("FAIL rnd%0d_flags: dropped/err/ovf=%b%b%b, required %b%b%b",
          it, m_drop, m_err, m_ovf, e_drop, e_err, e_ovf);
      end
      if (!e_drop) begin
        n_cmp++;
        if (int'(m_len) !== e_q.size() || (e_q.size() > 0 && m_bits !== e_bits)) begin
          n_bad++; $display("FAIL rnd%0d_len: len/bits=%0d/%0d, required %0d/%0d",
            it, m_len, m_bits, e_q.size(), e_bits);
        end
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
        n_cmp++;
        if (m_crc !== e_crc) begin
          n_bad++; $display("FAIL rnd%0d_crc: crc_ok=%b, required %b", it, m_crc, e_crc);
        end
`endif
      end
      if (!e_drop && e_q.size() > 0) begin
        idx = 0; cyc = 0;
        while (idx < e_q.size() && cyc < 200) begin
          rd_ready = 1'($urandom_range(0, 1));
          n_cmp++;
          if ({m_rd_valid, m_rd_data, m_rd_last} !== {1'b1, e_q[idx], idx == e_q.size() - 1}) begin
            n_bad++; $display("FAIL rnd%0d_rd%0d: valid/data/last=%b/%h/%b, required 1/%h/%b",
              it, idx, m_rd_valid, m_rd_data, m_rd_last, e_q[idx], idx == e_q.size() - 1);
          end
          tick();
          if (rd_ready) idx++;
          cyc++;
        end
        rd_ready = 1'b0;
      end
      n_cmp++;
      if (m_rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_end: rd_valid=%b, required 0", it, m_rd_valid);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; soc = 1'b0; eoc = 1'b0; dv = 1'b0; seq = 1'b0; par = 1'b0;
    rd_ready = 1'b0; data = 8'h00; bits = 3'd0;
    tick();
    test_reset();
    test_basic();
    test_partial();
    test_error();
    test_empty();
    test_overflow_busy();
    test_reset_mid();
`ifdef RX_FRAME_BUFFER_CRC_CHECK_EN
    test_crc();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
